// File: rtl/j4a_seq_pkg.sv
// Shared state and phase encodings for the J4A phase sequencer.
// Latency: n/a (constants only).
// Backpressure: n/a.
package j4a_seq_pkg;

    typedef logic [1:0] state_t;
    typedef logic [1:0] phase_t;

    localparam state_t S_IDLE = 2'b00;
    localparam state_t S_RUN  = 2'b01;
    localparam state_t S_STEP = 2'b10;

    localparam phase_t T0 = 2'b00;  // fetch
    localparam phase_t T1 = 2'b01;  // decode
    localparam phase_t T2 = 2'b10;  // execute
    localparam phase_t T3 = 2'b11;  // writeback

    function automatic logic is_active(input state_t s);
        return s != S_IDLE;
    endfunction

endpackage

// File: rtl/j4a_phase_sequencer_if.sv
// Control inputs and phase/status outputs of the J4A phase sequencer.
// Latency: n/a (wiring only).
// Backpressure: mem_ready stalls the fetch phase; nothing else pushes back.
interface j4a_phase_sequencer_if #(
    parameter int COUNT_W = 8
);
    logic               run;
    logic               step;
    logic               halt;
    logic               mem_ready;
    logic               halt_insn;
    logic               phase_a;
    logic               phase_b;
    logic               phase_en;
    logic               busy;
    logic               insn_done;
    logic               halted;
    logic               timeout;
    logic [COUNT_W-1:0] insn_count;

    modport master (
        output run, step, halt, mem_ready, halt_insn,
        input  phase_a, phase_b, phase_en, busy, insn_done, halted, timeout, insn_count
    );

    modport slave (
        input  run, step, halt, mem_ready, halt_insn,
        output phase_a, phase_b, phase_en, busy, insn_done, halted, timeout, insn_count
    );
endinterface

// File: rtl/j4a_wait_timer.sv
// Counts fetch stall cycles; expired flags the count reaching WAIT_MAX.
// Latency: expired reflects the registered count (one cycle after count_en).
// Backpressure: none; clear wins over count_en.
module j4a_wait_timer #(
    parameter int WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic count_en,
    input  logic clear,
    output logic expired
);
    localparam int W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

    logic [W-1:0] wait_cnt_q, wait_cnt_d;

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (clear) begin
            wait_cnt_d = '0;
        end else if (count_en) begin
            wait_cnt_d = wait_cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign expired = (wait_cnt_q == W'(WAIT_MAX));

endmodule

// File: rtl/j4a_phase_sequencer.sv
// Sequences T0..T3 instruction phases for the J4A 2-to-4 phase decoder.
// Latency: run/step at edge n gives phase_en with T0 after edge n; 4 cycles per zero-wait insn.
// Backpressure: mem_ready=0 holds T0 until data arrives or WAIT_MAX expires.
module j4a_phase_sequencer
    import j4a_seq_pkg::*;
#(
    parameter int COUNT_W  = 8,
    parameter int WAIT_MAX = 15
) (
    input logic                  clk,
    input logic                  rst_n,
    j4a_phase_sequencer_if.slave bus
);
    state_t             state_q, state_d;
    phase_t             ph_q, ph_d;
    logic               halt_pending_q, halt_pending_d;
    logic               hlt_seen_q, hlt_seen_d;
    logic               halted_q, halted_d;
    logic               timeout_q, timeout_d;
    logic [COUNT_W-1:0] count_q, count_d;

    logic wait_en;
    logic wait_clr;
    logic wait_expired;
    logic active;

    assign active = is_active(state_q);

    j4a_wait_timer #(
        .WAIT_MAX(WAIT_MAX)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .count_en(wait_en),
        .clear   (wait_clr),
        .expired (wait_expired)
    );

    always_comb begin
        state_d        = state_q;
        ph_d           = ph_q;
        halt_pending_d = halt_pending_q;
        hlt_seen_d     = hlt_seen_q;
        halted_d       = halted_q;
        timeout_d      = timeout_q;
        count_d        = count_q;
        wait_en        = 1'b0;
        wait_clr       = 1'b0;

        if (!active) begin
            wait_clr = 1'b1;
            if (bus.run || bus.step) begin
                state_d   = bus.run ? S_RUN : S_STEP;
                ph_d      = T0;
                halted_d  = 1'b0;
                timeout_d = 1'b0;
            end
        end else begin
            if (bus.halt) begin
                halt_pending_d = 1'b1;
            end
            case (ph_q)
                T0: begin
                    if (bus.mem_ready) begin
                        ph_d     = T1;
                        wait_clr = 1'b1;
                    end else if (wait_expired) begin
                        // Abandon the fetch: instruction is not retired.
                        state_d        = S_IDLE;
                        ph_d           = T0;
                        timeout_d      = 1'b1;
                        halt_pending_d = 1'b0;
                        hlt_seen_d     = 1'b0;
                        wait_clr       = 1'b1;
                    end else begin
                        wait_en = 1'b1;
                    end
                end
                T1: ph_d = T2;
                T2: begin
                    ph_d = T3;
                    if (bus.halt_insn) begin
                        hlt_seen_d = 1'b1;
                    end
                end
                default: begin
                    ph_d           = T0;
                    count_d        = count_q + COUNT_W'(1);
                    halted_d       = hlt_seen_q;
                    halt_pending_d = 1'b0;
                    hlt_seen_d     = 1'b0;
                    // A halt pulse in this very T3 still stops here.
                    if ((state_q == S_STEP) || !bus.run || halt_pending_q ||
                        bus.halt || hlt_seen_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            ph_q           <= T0;
            halt_pending_q <= 1'b0;
            hlt_seen_q     <= 1'b0;
            halted_q       <= 1'b0;
            timeout_q      <= 1'b0;
            count_q        <= '0;
        end else begin
            state_q        <= state_d;
            ph_q           <= ph_d;
            halt_pending_q <= halt_pending_d;
            hlt_seen_q     <= hlt_seen_d;
            halted_q       <= halted_d;
            timeout_q      <= timeout_d;
            count_q        <= count_d;
        end
    end

    assign bus.phase_a    = active & ph_q[1];
    assign bus.phase_b    = active & ph_q[0];
    assign bus.phase_en   = active;
    assign bus.busy       = active;
    assign bus.insn_done  = active & (ph_q == T3);
    assign bus.halted     = halted_q;
    assign bus.timeout    = timeout_q;
    assign bus.insn_count = count_q;

endmodule

// File: tb/tb_j4a_phase_sequencer.sv
// Randomized and directed stimulus for j4a_phase_sequencer, checked per cycle
// against an instruction-level reference model through an expectation queue.
module tb_j4a_phase_sequencer;
    localparam int CW   = 8;
    localparam int WMAX = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    j4a_phase_sequencer_if #(.COUNT_W(CW)) bus ();

    j4a_phase_sequencer #(
        .COUNT_W (CW),
        .WAIT_MAX(WMAX)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Reference model: mode 0=idle 1=run 2=step, phase as integer 0..3.
    int mode, ph, waits, cnt;
    bit pend, seen, m_halted, m_tmo;

    logic [14:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    function automatic logic [14:0] model_out();
        logic act;
        logic [1:0] p;
        act = (mode != 0);
        p = act ? 2'(ph) : 2'b00;
        return {p[1], p[0], act, act, act && (ph == 3), m_halted, m_tmo, 8'(cnt)};
    endfunction

    task automatic model_step(input bit r_n, input bit rn, input bit st,
                              input bit hl, input bit mr, input bit hi);
        bit stop;
        if (!r_n) begin
            mode = 0; ph = 0; waits = 0; cnt = 0;
            pend = 0; seen = 0; m_halted = 0; m_tmo = 0;
        end else if (mode == 0) begin
            if (rn || st) begin
                mode = rn ? 1 : 2;
                ph = 0; waits = 0; m_halted = 0; m_tmo = 0;
            end
        end else begin
            if (hl) pend = 1;
            if (ph == 0 && !mr) begin
                if (waits == WMAX) begin
                    mode = 0; ph = 0; waits = 0; m_tmo = 1; pend = 0; seen = 0;
                end else begin
                    waits++;
                end
            end else if (ph == 3) begin
                cnt = (cnt + 1) % (1 << CW);
                stop = (mode == 2) || !rn || pend || seen;
                m_halted = seen;
                pend = 0; seen = 0; ph = 0;
                mode = stop ? 0 : 1;
            end else begin
                if (ph == 2 && hi) seen = 1;
                if (ph == 0) waits = 0;
                ph++;
            end
        end
    endtask

    task automatic cycle(input bit r_n, input bit rn, input bit st,
                         input bit hl, input bit mr, input bit hi);
        @(negedge clk);
        rst_n         = r_n;
        bus.run       = rn;
        bus.step      = st;
        bus.halt      = hl;
        bus.mem_ready = mr;
        bus.halt_insn = hi;
        model_step(r_n, rn, st, hl, mr, hi);
        exp_q.push_back(model_out());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 1, 0);
    endtask

    // Monitor: one expected snapshot per clock edge.
    initial begin
        logic [14:0] e, a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {bus.phase_a, bus.phase_b, bus.phase_en, bus.busy, bus.insn_done,
                     bus.halted, bus.timeout, bus.insn_count};
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL outputs t=%0t got{a,b,en,busy,done,hlt,tmo,cnt}=%b_%h required=%b_%h",
                             $time, a[14:8], a[7:0], e[14:8], e[7:0]);
                end
            end
        end
    end

    initial begin
        bus.run = 0; bus.step = 0; bus.halt = 0; bus.mem_ready = 0; bus.halt_insn = 0;
        mode = 0; ph = 0; waits = 0; cnt = 0;
        pend = 0; seen = 0; m_halted = 0; m_tmo = 0;

        // Reset, then free run with zero waits.
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 13; i++) cycle(1, 1, 0, 0, 1, 0);
        for (int i = 0; i < 6; i++) cycle(1, 0, 0, 0, 1, 0);

        // Single step, second step during T1 ignored.
        cycle(1, 0, 1, 0, 1, 0);
        cycle(1, 0, 0, 0, 1, 0);
        cycle(1, 0, 1, 0, 1, 0);
        idle(6);

        // Three wait states in T0.
        cycle(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 1, 0);
        cycle(1, 0, 0, 0, 1, 0);
        idle(6);

        // Fetch timeout, then a fresh run clears it.
        for (int i = 0; i < 18; i++) cycle(1, (i < 17), 0, 0, 0, 0);
        idle(3);
        for (int i = 0; i < 6; i++) cycle(1, (i < 2), 0, 0, 1, 0);
        idle(2);

        // HLT in the second instruction's T2, then a halt pulse in T1.
        for (int i = 0; i < 12; i++) cycle(1, 1, 0, 0, 1, (i == 7));
        idle(2);
        for (int i = 0; i < 12; i++) cycle(1, 1, 0, (i == 6), 1, 0);
        idle(2);

        // Halt pulse landing exactly in T3 and halt while idle.
        for (int i = 0; i < 8; i++) cycle(1, 1, 0, (i == 4), 1, 0);
        cycle(1, 0, 0, 1, 1, 0);
        idle(2);

        // Counter wrap past 255.
        for (int i = 0; i < 1100; i++) cycle(1, 1, 0, 0, 1, 0);
        idle(6);

        // Reset mid-T2.
        for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0, 1, 0);
        cycle(0, 1, 0, 0, 1, 0);
        idle(3);

        // Random mix.
        for (int i = 0; i < 800; i++) begin
            cycle(($urandom_range(0, 199) != 0),
                  ($urandom_range(0, 9) < 8),
                  ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 29) == 0),
                  ($urandom_range(0, 9) < 8),
                  ($urandom_range(0, 19) == 0));
        end
        for (int i = 0; i < 60; i++) cycle(1, 1, 0, 0, ($urandom_range(0, 19) == 0), 0);
        idle(8);

        repeat (3) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain leftover=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
